hiscore_xfer: RTL

//  Initiator for the core's high-score RAM port (hs_address/hs_data_in/hs_data_out/hs_write/hs_access).

---
 rtl/hiscore_xfer.sv | 114 +++++++++++
 1 files changed

// File: rtl/hiscore_xfer.sv
// hiscore_xfer: initiator for the core's high-score RAM port (SAVE: RAM -> host stream, LOAD: host stream -> RAM)
// Ports:
//   clk_49m, reset_n           system clock, asynchronous active-low reset
//   start_save, start_load     1-cycle start pulses (SAVE wins if both)
//   abort                      level, ends the current transfer and sets err
//   hs_address, hs_data_in     address / write data to the core
//   hs_data_out                read data from the core (RD_LAT cycles after address)
//   hs_write, hs_access        write strobe / port ownership request
//   up_data, up_valid, up_ready    SAVE byte stream to the host
//   dn_data, dn_valid, dn_ready    LOAD byte stream from the host
//   busy, done, err            status: in progress, end-of-transfer pulse, sticky abort flag
module hiscore_xfer #(
    parameter int                ADDR_W    = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                LENGTH    = 64,
    parameter int                ACQ_CYC   = 4,
    parameter int                RD_LAT    = 2
) (
    input  logic              clk_49m,
    input  logic              reset_n,
    input  logic              start_save,
    input  logic              start_load,
    input  logic              abort,
    output logic [ADDR_W-1:0] hs_address,
    output logic [7:0]        hs_data_in,
    input  logic [7:0]        hs_data_out,
    output logic              hs_write,
    output logic              hs_access,
    output logic [7:0]        up_data,
    output logic              up_valid,
    input  logic              up_ready,
    input  logic [7:0]        dn_data,
    input  logic              dn_valid,
    output logic              dn_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, ACQ, RD_WAIT, RD_PUSH, WR_WAIT, WR_STB, NEXT, REL} state_t;
    localparam int CNT_W   = $clog2(LENGTH + 1);
    localparam int TMR_MAX = ACQ_CYC > RD_LAT ? ACQ_CYC : RD_LAT + 1;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    state_t             state;
    logic               save;
    logic [CNT_W-1:0]   cnt;
    logic [TMR_W-1:0]   tmr;
    // Control outputs decode the state register only, so they fall together
    // with the asynchronous reset and never combinationally follow an input.
    assign busy      = state != IDLE;
    assign hs_access = state != IDLE && state != REL;
    assign up_valid  = state == RD_PUSH;
    assign dn_ready  = state == WR_WAIT;
    assign hs_write  = state == WR_STB;
    assign done      = state == REL;
    // hs_address doubles as the byte pointer; it wraps naturally at 2**ADDR_W.
    // RD_WAIT spans RD_LAT+1 cycles so the capture edge lands on the cycle in
    // which the core's read data for the current address is valid.
    always_ff @(posedge clk_49m or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            save       <= 1'b0;
            cnt        <= '0;
            tmr        <= '0;
            hs_address <= BASE_ADDR;
            hs_data_in <= '0;
            up_data    <= '0;
            err        <= 1'b0;
        end else if (abort && state != IDLE && state != REL) begin
            state <= REL;
            err   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (start_save || start_load) begin
                    state      <= ACQ;
                    save       <= start_save;
                    err        <= 1'b0;
                    cnt        <= '0;
                    tmr        <= '0;
                    hs_address <= BASE_ADDR;
                end
                ACQ: if (tmr == TMR_W'(ACQ_CYC - 1)) begin
                    tmr   <= '0;
                    state <= save ? RD_WAIT : WR_WAIT;
                end else begin
                    tmr <= tmr + 1'b1;
                end
                RD_WAIT: if (tmr == TMR_W'(RD_LAT)) begin
                    tmr     <= '0;
                    up_data <= hs_data_out;
                    state   <= RD_PUSH;
                end else begin
                    tmr <= tmr + 1'b1;
                end
                RD_PUSH: if (up_ready) state <= NEXT;
                WR_WAIT: if (dn_valid) begin
                    hs_data_in <= dn_data;
                    state      <= WR_STB;
                end
                WR_STB: state <= NEXT;
                NEXT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(LENGTH - 1)) begin
                        state <= REL;
                    end else begin
                        hs_address <= hs_address + 1'b1;
                        state      <= save ? RD_WAIT : WR_WAIT;
                    end
                end
                REL: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
